// File: rtl/axi_pkg.sv
// Shared AXI4 read-side types: burst and response codes, responder FSM
// states and the latched AR request.
package axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
    } state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [7:0]  len;
        logic [2:0]  size;
        burst_e      burst;
    } ar_req_t;

    // A WRAP burst must cover a power-of-two container: 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_legal(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst address sequencer: next beat address for
// FIXED/INCR/WRAP plus a legality flag for the burst attributes.
module axi_burst_addr_gen
    import axi_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [2:0]  size,
    input  logic [7:0]  len,
    input  burst_e      burst,
    output logic [31:0] next_addr,
    output logic        legal
);

    logic [31:0] step;
    logic [31:0] wrap_mask;
    logic [31:0] incr_addr;

    // Next address: FIXED holds, INCR steps, WRAP steps inside the container.
    // NOTE: every signal driven here is assigned a default first, so no path leaves it unassigned and a latch cannot be inferred.
    always_comb begin
        step      = 32'd1 << size;
        wrap_mask = ((32'(len) + 32'd1) << size) - 32'd1;
        incr_addr = addr + step;
        next_addr = addr;
        case (burst)
            BURST_INCR: next_addr = incr_addr;
            BURST_WRAP: next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
            default:    next_addr = addr;
        endcase
    end

    // Legality: beats no wider than the 32-bit bus, no reserved burst, sane WRAP length.
    always_comb begin
        legal = (size <= 3'd2) && (burst != BURST_RSVD);
        if ((burst == BURST_WRAP) && !wrap_len_legal(len)) begin
            legal = 1'b0;
        end
    end

endmodule

// File: rtl/axi_rd_sram_slave.sv
// AXI4 read responder (AR/R) in front of a word-addressed SRAM model with a
// programmable first-beat latency, per-beat address decode and a preload port.
module axi_rd_sram_slave
    import axi_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h3000_0000,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic [31:0] i_axi_araddr,
    input  logic        i_axi_arvalid,
    output logic        o_axi_arready,
    input  logic [3:0]  i_axi_arid,
    input  logic [7:0]  i_axi_arlen,
    input  logic [2:0]  i_axi_arsize,
    input  logic [1:0]  i_axi_arburst,
    output logic [31:0] o_axi_rdata,
    output logic        o_axi_rvalid,
    input  logic        i_axi_rready,
    output logic [1:0]  o_axi_rresp,
    output logic [3:0]  o_axi_rid,
    output logic        o_axi_rlast,
    input  logic        i_wen,
    input  logic [31:0] i_waddr,
    input  logic [31:0] i_wdata
);

    localparam int unsigned AW   = $clog2(DEPTH * 4);
    localparam logic [31:0] SPAN = 32'(DEPTH * 4);
    localparam logic [3:0]  LAT  = 4'(LATENCY);

    state_e      state;
    state_e      state_next;
    ar_req_t     req;
    logic [7:0]  beat_cnt;   // beats remaining after the one currently presented
    logic [3:0]  lat_cnt;
    logic [31:0] mem [DEPTH];

    logic        ar_hs;
    logic        r_hs;
    logic        first_load;
    logic        next_load;
    logic        load_beat;
    logic        burst_legal;
    logic        beat_decerr;
    logic [31:0] next_addr;
    logic [31:0] beat_addr;
    logic [31:0] beat_off;
    logic [31:0] beat_data;
    logic [31:0] wr_off;

    axi_burst_addr_gen u_addr_gen (
        .addr      (req.addr),
        .size      (req.size),
        .len       (req.len),
        .burst     (req.burst),
        .next_addr (next_addr),
        .legal     (burst_legal)
    );

    assign ar_hs     = i_axi_arvalid && o_axi_arready;
    assign r_hs      = o_axi_rvalid && i_axi_rready;
    assign load_beat = first_load || next_load;

    // A follow-on beat is fetched from the advanced address in the same cycle
    // the current beat is accepted, so back-to-back beats need no bubble.
    assign beat_addr   = next_load ? next_addr : req.addr;
    assign beat_off    = beat_addr - BASE;
    assign beat_decerr = (beat_off >= SPAN);
    assign beat_data   = mem[beat_off[AW-1:2]];
    assign wr_off      = i_waddr - BASE;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: accept AR, count down latency, stream beats until the last handshake.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (ar_hs)                  state_next = (LAT == 4'd0) ? ST_DATA : ST_WAIT;
            ST_WAIT: if (lat_cnt <= 4'd1)        state_next = ST_DATA;
            ST_DATA: if (r_hs && o_axi_rlast)    state_next = ST_IDLE;
            default:                             state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: arready in IDLE, first beat load on DATA entry, follow-on load on accept.
    always_comb begin
        o_axi_arready = 1'b0;
        first_load    = 1'b0;
        next_load     = 1'b0;
        case (state)
            ST_IDLE: o_axi_arready = !i_reset;
            ST_DATA: begin
                first_load = !o_axi_rvalid;
                next_load  = r_hs && !o_axi_rlast;
            end
            default: ;
        endcase
    end

    // Request, beat and latency counters.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            req      <= '0;
            beat_cnt <= '0;
            lat_cnt  <= '0;
        end else if (ar_hs) begin
            req <= '{addr:  i_axi_araddr,
                     id:    i_axi_arid,
                     len:   i_axi_arlen,
                     size:  i_axi_arsize,
                     burst: burst_e'(i_axi_arburst)};
            beat_cnt <= i_axi_arlen;
            lat_cnt  <= LAT;
        end else begin
            if ((state == ST_WAIT) && (lat_cnt != 4'd0)) begin
                lat_cnt <= lat_cnt - 4'd1;
            end
            if (next_load) begin
                req.addr <= next_addr;
                beat_cnt <= beat_cnt - 8'd1;
            end
        end
    end

    // R channel registers: load a beat with its decode result, hold while stalled.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_axi_rvalid <= 1'b0;
            o_axi_rlast  <= 1'b0;
            o_axi_rresp  <= RESP_OKAY;
            o_axi_rid    <= '0;
            o_axi_rdata  <= '0;
        end else if (load_beat) begin
            o_axi_rvalid <= 1'b1;
            o_axi_rid    <= req.id;
            o_axi_rlast  <= first_load ? (beat_cnt == 8'd0) : (beat_cnt == 8'd1);
            if (!burst_legal) begin
                o_axi_rresp <= RESP_SLVERR;
                o_axi_rdata <= '0;
            end else if (beat_decerr) begin
                o_axi_rresp <= RESP_DECERR;
                o_axi_rdata <= '0;
            end else begin
                o_axi_rresp <= RESP_OKAY;
                o_axi_rdata <= beat_data;
            end
        end else if (r_hs) begin
            o_axi_rvalid <= 1'b0;
            o_axi_rlast  <= 1'b0;
        end
    end

    // Preload write port; out-of-range addresses are dropped.
    // NOTE: the storage array is deliberately left out of reset; contents survive reset and only control state is cleared.
    always_ff @(posedge i_clock) begin
        if (i_wen && (wr_off < SPAN)) begin
            mem[wr_off[AW-1:2]] <= i_wdata;
        end
    end

endmodule

// File: tb/tb_axi_rd_sram_slave.sv
// Directed bench for axi_rd_sram_slave: a table of single-transaction reads
// with hand-computed beats, plus sequences for backpressure, same-cycle
// preload, a 256-beat burst and reset in the middle of a burst.
module tb_axi_rd_sram_slave;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam int          DEPTH   = 1024;
    localparam int          LATENCY = 2;

    localparam logic [1:0] FIX = 2'b00;
    localparam logic [1:0] INC = 2'b01;
    localparam logic [1:0] WRP = 2'b10;
    localparam logic [1:0] OK  = 2'b00;
    localparam logic [1:0] SLV = 2'b10;
    localparam logic [1:0] DEC = 2'b11;

    typedef struct packed {
        logic [31:0]      addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [3:0]       id;
        logic [2:0]       nbeats;
        logic [3:0][31:0] data;
        logic [3:0][1:0]  resp;
    } vec_t;

    localparam int NV = 11;

    logic        i_clock;
    logic        i_reset;
    logic [31:0] i_axi_araddr;
    logic        i_axi_arvalid;
    logic        o_axi_arready;
    logic [3:0]  i_axi_arid;
    logic [7:0]  i_axi_arlen;
    logic [2:0]  i_axi_arsize;
    logic [1:0]  i_axi_arburst;
    logic [31:0] o_axi_rdata;
    logic        o_axi_rvalid;
    logic        i_axi_rready;
    logic [1:0]  o_axi_rresp;
    logic [3:0]  o_axi_rid;
    logic        o_axi_rlast;
    logic        i_wen;
    logic [31:0] i_waddr;
    logic [31:0] i_wdata;

    int   n_cmp;
    int   n_err;
    vec_t vecs [NV];

    axi_rd_sram_slave #(
        .BASE    (BASE),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_axi_araddr  (i_axi_araddr),
        .i_axi_arvalid (i_axi_arvalid),
        .o_axi_arready (o_axi_arready),
        .i_axi_arid    (i_axi_arid),
        .i_axi_arlen   (i_axi_arlen),
        .i_axi_arsize  (i_axi_arsize),
        .i_axi_arburst (i_axi_arburst),
        .o_axi_rdata   (o_axi_rdata),
        .o_axi_rvalid  (o_axi_rvalid),
        .i_axi_rready  (i_axi_rready),
        .o_axi_rresp   (o_axi_rresp),
        .o_axi_rid     (o_axi_rid),
        .o_axi_rlast   (o_axi_rlast),
        .i_wen         (i_wen),
        .i_waddr       (i_waddr),
        .i_wdata       (i_wdata)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach the summary line");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, input logic [7:0] len,
                                input logic [2:0] size, input logic [1:0] burst,
                                input logic [3:0] id, input logic [2:0] nb,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [1:0] r0, input logic [1:0] r1,
                                input logic [1:0] r2, input logic [1:0] r3);
        vec_t v;
        v.addr    = addr;
        v.len     = len;
        v.size    = size;
        v.burst   = burst;
        v.id      = id;
        v.nbeats  = nb;
        v.data[0] = d0;
        v.data[1] = d1;
        v.data[2] = d2;
        v.data[3] = d3;
        v.resp[0] = r0;
        v.resp[1] = r1;
        v.resp[2] = r2;
        v.resp[3] = r3;
        return v;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        i_wen   = 1'b1;
        i_waddr = a;
        i_wdata = d;
        @(negedge i_clock);
        i_wen   = 1'b0;
    endtask

    // Presents one AR from a negedge in IDLE; returns at the negedge after the handshake edge.
    task automatic send_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        check("arready before AR", 32'(o_axi_arready), 32'd1);
        i_axi_araddr  = a;
        i_axi_arlen   = len;
        i_axi_arsize  = size;
        i_axi_arburst = burst;
        i_axi_arid    = id;
        i_axi_arvalid = 1'b1;
        @(posedge i_clock);
        @(negedge i_clock);
        i_axi_arvalid = 1'b0;
    endtask

    // Counts clock edges after the AR handshake until rvalid is seen (bounded).
    task automatic wait_rvalid(output int n);
        n = 0;
        while (!o_axi_rvalid && n < 40) begin
            @(negedge i_clock);
            n++;
        end
    endtask

    task automatic run_vector(input vec_t v, input int k);
        int n;
        send_ar(v.addr, v.len, v.size, v.burst, v.id);
        wait_rvalid(n);
        check($sformatf("v%0d first-beat latency", k), 32'(n), 32'(LATENCY + 1));
        check($sformatf("v%0d arready busy", k), 32'(o_axi_arready), 32'd0);
        for (int b = 0; b < int'(v.nbeats); b++) begin
            check($sformatf("v%0d b%0d rvalid", k, b), 32'(o_axi_rvalid), 32'd1);
            check($sformatf("v%0d b%0d rdata", k, b), o_axi_rdata, v.data[b]);
            check($sformatf("v%0d b%0d rresp", k, b), 32'(o_axi_rresp), 32'(v.resp[b]));
            check($sformatf("v%0d b%0d rlast", k, b), 32'(o_axi_rlast),
                  (b == int'(v.nbeats) - 1) ? 32'd1 : 32'd0);
            check($sformatf("v%0d b%0d rid", k, b), 32'(o_axi_rid), 32'(v.id));
            @(negedge i_clock);
        end
        check($sformatf("v%0d rvalid after last", k), 32'(o_axi_rvalid), 32'd0);
        check($sformatf("v%0d arready after last", k), 32'(o_axi_arready), 32'd1);
    endtask

    initial begin
        int n;
        int beats;
        int bad;
        logic done;
        logic stray;

        n_cmp         = 0;
        n_err         = 0;
        i_reset       = 1'b1;
        i_axi_araddr  = '0;
        i_axi_arvalid = 1'b0;
        i_axi_arid    = '0;
        i_axi_arlen   = '0;
        i_axi_arsize  = '0;
        i_axi_arburst = '0;
        i_axi_rready  = 1'b1;
        i_wen         = 1'b0;
        i_waddr       = '0;
        i_wdata       = '0;

        //           addr            len   size  burst id  nb  d0            d1     d2     d3     r0   r1   r2   r3
        vecs[0]  = mk(BASE + 32'h14,  8'd0, 3'd2, INC, 4'd3,  3'd1, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, OK,  OK,  OK,  OK);
        vecs[1]  = mk(BASE + 32'h38,  8'd3, 3'd2, WRP, 4'd1,  3'd4, 32'd14, 32'd15, 32'd12, 32'd13,      OK,  OK,  OK,  OK);
        vecs[2]  = mk(BASE + 32'h38,  8'd2, 3'd2, WRP, 4'd2,  3'd3, 32'd0,  32'd0,  32'd0,  32'd0,       SLV, SLV, SLV, OK);
        vecs[3]  = mk(BASE + 32'hFF8, 8'd3, 3'd2, INC, 4'd4,  3'd4, 32'd1022, 32'd1023, 32'd0, 32'd0,    OK,  OK,  DEC, DEC);
        vecs[4]  = mk(BASE - 32'h4,   8'd0, 3'd2, INC, 4'd5,  3'd1, 32'd0,  32'd0,  32'd0,  32'd0,       DEC, OK,  OK,  OK);
        vecs[5]  = mk(BASE + 32'h8,   8'd3, 3'd2, FIX, 4'd6,  3'd4, 32'd2,  32'd2,  32'd2,  32'd2,       OK,  OK,  OK,  OK);
        vecs[6]  = mk(BASE,           8'd0, 3'd3, INC, 4'd7,  3'd1, 32'd0,  32'd0,  32'd0,  32'd0,       SLV, OK,  OK,  OK);
        vecs[7]  = mk(BASE,           8'd3, 3'd1, INC, 4'd8,  3'd4, 32'd0,  32'd0,  32'd1,  32'd1,       OK,  OK,  OK,  OK);
        vecs[8]  = mk(BASE + 32'h4,   8'd1, 3'd2, WRP, 4'd9,  3'd2, 32'd1,  32'd0,  32'd0,  32'd0,       OK,  OK,  OK,  OK);
        vecs[9]  = mk(BASE,           8'd1, 3'd2, 2'b11, 4'd10, 3'd2, 32'd0, 32'd0, 32'd0,  32'd0,       SLV, SLV, OK,  OK);
        vecs[10] = mk(BASE - 32'h4,   8'd0, 3'd3, INC, 4'd11, 3'd1, 32'd0,  32'd0,  32'd0,  32'd0,       SLV, OK,  OK,  OK);

        // Reset state.
        repeat (2) @(negedge i_clock);
        check("reset arready", 32'(o_axi_arready), 32'd0);
        check("reset rvalid", 32'(o_axi_rvalid), 32'd0);
        check("reset rlast", 32'(o_axi_rlast), 32'd0);
        check("reset rdata", o_axi_rdata, 32'd0);
        check("reset rresp/rid", {26'd0, o_axi_rresp, o_axi_rid}, 32'd0);
        i_reset = 1'b0;
        @(negedge i_clock);
        check("arready after reset", 32'(o_axi_arready), 32'd1);

        // Contents: mem[i] = i, mem[5] = DEADBEEF; an out-of-range write must not alias word 0.
        for (int i = 0; i < DEPTH; i++) begin
            preload(BASE + 32'(i * 4), (i == 5) ? 32'hDEADBEEF : 32'(i));
        end
        preload(BASE + 32'(DEPTH * 4), 32'h0000_0BAD);

        for (int k = 0; k < NV; k++) begin
            run_vector(vecs[k], k);
        end

        // INCR with beat 1 stalled for three cycles.
        send_ar(BASE, 8'd3, 3'd2, INC, 4'd12);
        wait_rvalid(n);
        check("bp latency", 32'(n), 32'(LATENCY + 1));
        check("bp b0 rdata", o_axi_rdata, 32'd0);
        @(negedge i_clock);
        check("bp b1 rdata", o_axi_rdata, 32'd1);
        i_axi_rready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge i_clock);
            check($sformatf("bp stall%0d rvalid", s), 32'(o_axi_rvalid), 32'd1);
            check($sformatf("bp stall%0d rdata", s), o_axi_rdata, 32'd1);
            check($sformatf("bp stall%0d rlast", s), 32'(o_axi_rlast), 32'd0);
        end
        i_axi_rready = 1'b1;
        @(negedge i_clock);
        check("bp b2 rdata", o_axi_rdata, 32'd2);
        check("bp b2 rlast", 32'(o_axi_rlast), 32'd0);
        @(negedge i_clock);
        check("bp b3 rdata", o_axi_rdata, 32'd3);
        check("bp b3 rlast", 32'(o_axi_rlast), 32'd1);
        @(negedge i_clock);
        check("bp rvalid after last", 32'(o_axi_rvalid), 32'd0);

        // Preload into the addressed word in the very cycle the beat is loaded.
        send_ar(BASE + 32'h50, 8'd0, 3'd2, INC, 4'd14);
        @(negedge i_clock);
        @(negedge i_clock);
        i_wen   = 1'b1;
        i_waddr = BASE + 32'h50;
        i_wdata = 32'hCAFEF00D;
        @(negedge i_clock);
        i_wen   = 1'b0;
        check("same-cycle rvalid", 32'(o_axi_rvalid), 32'd1);
        check("same-cycle old data", o_axi_rdata, 32'd20);
        @(negedge i_clock);
        run_vector(mk(BASE + 32'h50, 8'd0, 3'd2, INC, 4'd14, 3'd1, 32'hCAFEF00D, 32'd0, 32'd0, 32'd0,
                      OK, OK, OK, OK), 90);

        // len=255: the 8-bit beat counter must deliver all 256 beats.
        send_ar(BASE + 32'h8, 8'd255, 3'd2, FIX, 4'd15);
        beats = 0;
        bad   = 0;
        done  = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            if (o_axi_rvalid) begin
                beats++;
                if (o_axi_rdata !== 32'd2) bad++;
                if (o_axi_rlast) done = 1'b1;
            end
            @(negedge i_clock);
        end
        check("len255 beat count", 32'(beats), 32'd256);
        check("len255 bad data", 32'(bad), 32'd0);
        check("len255 rvalid after last", 32'(o_axi_rvalid), 32'd0);

        // Reset during beat 2 of a len=7 burst.
        send_ar(BASE, 8'd7, 3'd2, INC, 4'd13);
        wait_rvalid(n);
        @(negedge i_clock);
        @(negedge i_clock);
        check("mid-burst b2 rdata", o_axi_rdata, 32'd2);
        i_reset = 1'b1;
        #1;
        check("mid-reset rvalid", 32'(o_axi_rvalid), 32'd0);
        check("mid-reset rdata", o_axi_rdata, 32'd0);
        check("mid-reset rlast", 32'(o_axi_rlast), 32'd0);
        check("mid-reset arready", 32'(o_axi_arready), 32'd0);
        check("mid-reset rresp/rid", {26'd0, o_axi_rresp, o_axi_rid}, 32'd0);
        @(negedge i_clock);
        @(negedge i_clock);
        i_reset = 1'b0;
        stray   = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clock);
            if (o_axi_rvalid) stray = 1'b1;
        end
        check("no residual beat", 32'(stray), 32'd0);
        check("arready after mid reset", 32'(o_axi_arready), 32'd1);
        run_vector(vecs[1], 91);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
